i2c_txn_arbiter: RTL
====================

Name: i2c_txn_arbiter

Overview:
- Shares one I2C transaction engine (GO/WR/END/ACK handshake, 24-bit {slave, sub-addr, data} word) between two requesters.
- Port 0 is the power-up register-table sequencer. Port 1 is the runtime tuner (exposure/gain tweaks for gesture detection).
- Arbitrates round-robin, latches the winner's command and drives the engine.
- Retries NACKed or timed-out transfers, then reports done or error per requester.

Parameters:
SLAVE_ADDR, 8'h42, camera write address placed in eng_wdata[23:16]
MAX_RETRY, 3, retries after the first failed attempt (4 attempts total)
TIMEOUT_TICKS, 64, i2c_tick count allowed per attempt before it counts as a failure

Ports:
iCLK  in  1  system clock (25 MHz)
iRST_N  in  1  asynchronous active-low reset
i2c_tick  in  1  one-iCLK strobe per I2C control-clock period (SCL-low phase); the FSM advances only on ticks
req_valid  in  2  per-port request; held until that port's done/err pulse
req_wr  in  2  1 = write, 0 = read
req_sub_addr  in  16  {port1, port0} 8-bit register addresses
req_wdata  in  16  {port1, port0} 8-bit write data
req_done  out  2  one-iCLK pulse, transfer ACKed
req_err  out  2  one-iCLK pulse, retries exhausted
rd_data  out  8  read result, valid from the req_done pulse until the next grant
grant  out  2  one-hot owner, 0 when idle
busy  out  1  grant != 0
err_count  out  8  saturating count of req_err pulses
eng_go  out  1  engine start level
eng_wr  out  1  engine direction
eng_wdata  out  24  {SLAVE_ADDR, latched sub, latched data}
eng_end  in  1  engine idle/complete (1), in transfer (0)
eng_ack  in  1  0 = slave ACKed, sampled when eng_end returns to 1
eng_rdata  in  8  engine read byte

Behaviour:
- Reset (async, iRST_N = 0):
  - All outputs 0, state IDLE.
  - last_grant = port 1, so port 0 wins the first tie.
  - attempt = 0, timer = 0.
  - Reset mid-transfer aborts it with no pulses.
- Tick gating: state, timer and eng_* change only on iCLK edges where i2c_tick = 1. req_done and req_err are single-iCLK pulses issued on such an edge.
- IDLE: on tick, if any req_valid is set, pick the winner.
  - Only one valid: that port wins.
  - Both valid: the port != last_grant wins.
  - Same edge: latch wr/sub/data, set grant, set last_grant, attempt = 0, timer = 0, eng_go = 1, eng_wr = latched wr. Go to LAUNCH.
- LAUNCH: hold eng_go.
  - eng_end = 0: go to BUSY.
  - Otherwise timer++.
- BUSY: hold eng_go.
  - eng_end = 1: eng_go = 0, go to CHECK.
  - Otherwise timer++.
- Timeout: if timer reaches TIMEOUT_TICKS in LAUNCH or BUSY, set eng_go = 0 and treat the attempt as a NACK (CHECK path with failure).
- CHECK:
  - ACK (eng_ack = 0, no timeout): if read, capture rd_data = eng_rdata; pulse req_done[owner]; grant = 0; go to IDLE.
  - Failure with attempt < MAX_RETRY: attempt++, timer = 0, go to GAP.
  - Failure with attempt = MAX_RETRY: pulse req_err[owner], err_count++ (saturating at 255), grant = 0, go to IDLE.
- GAP: one tick with eng_go = 0 so the engine rearms, then eng_go = 1 and go to LAUNCH. eng_wdata is unchanged.
- Command stability: eng_wdata and eng_wr stay constant from grant until return to IDLE. Requester input changes while granted are ignored.
- Deasserted request: if the owner drops req_valid mid-transfer, the transfer completes and the pulse is still issued.
- Idle turnaround: the earliest regrant is the tick after the pulse, since IDLE evaluates on the following tick. This gives port 1 a slot between table entries.
- No-tick case: with no ticks, nothing advances, including the timeout.

Test Plan:
1. Port 0 write sub 8'h12 data 8'h80, engine ACKs after 30 ticks:
   - eng_wdata = 24'h421280 and eng_go held through the transfer.
   - req_done = 2'b01 for exactly 1 iCLK; grant back to 0.
2. Both ports valid from reset:
   - Port 0 is granted first, then port 1.
   - With both held valid, grants alternate 01, 10, 01 across 3 transfers.
3. Port 1 read sub 8'h0A, engine returns 8'h76 with ACK: req_done = 2'b10, rd_data = 8'h76, eng_wr = 0 during the transfer.
4. Engine NACKs 3 times then ACKs: 4 eng_go rising edges, each separated by ≥ 1 tick low; single req_done, err_count = 0.
5. Engine never drops eng_end: each attempt ends after 64 ticks; after 4 attempts, req_err = 2'b01 pulses once and err_count = 1.
6. iRST_N pulsed low while in BUSY: all outputs 0 immediately; after release, the still-valid request is regranted on the first tick with attempt = 0.

Source files
------------

// File: rtl/i2c_txn_arbiter_if.sv
// ============================================================================
// Module : i2c_txn_arbiter_if
// Brief  : Requester and engine handshake bundle for the I2C transaction arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface i2c_txn_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_wr;
  logic [15:0] req_sub_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_done;
  logic [1:0]  req_err;
  logic [7:0]  rd_data;
  logic [1:0]  grant;
  logic        busy;
  logic [7:0]  err_count;
  logic        eng_go;
  logic        eng_wr;
  logic [23:0] eng_wdata;
  logic        eng_end;
  logic        eng_ack;
  logic [7:0]  eng_rdata;

  // Arbiter side
  modport master (
    input  req_valid, req_wr, req_sub_addr, req_wdata,
    input  eng_end, eng_ack, eng_rdata,
    output req_done, req_err, rd_data, grant, busy, err_count,
    output eng_go, eng_wr, eng_wdata
  );

  // Requester/engine side
  modport slave (
    output req_valid, req_wr, req_sub_addr, req_wdata,
    output eng_end, eng_ack, eng_rdata,
    input  req_done, req_err, rd_data, grant, busy, err_count,
    input  eng_go, eng_wr, eng_wdata
  );
endinterface

`default_nettype wire

// File: rtl/i2c_txn_arbiter.sv
// ============================================================================
// Module : i2c_txn_arbiter
// Brief  : Round-robin share of one I2C transaction engine between two
//          requesters, with retry on NACK/timeout and per-port done/err pulses.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module i2c_txn_arbiter #(
  parameter logic [7:0] SLAVE_ADDR    = 8'h42,
  parameter int         MAX_RETRY     = 3,
  parameter int         TIMEOUT_TICKS = 64
) (
  input  wire logic          iCLK,
  input  wire logic          iRST_N,
  input  wire logic          i2c_tick,
  i2c_txn_arbiter_if.master  bus
);

  localparam int c_TIMER_W = $clog2(TIMEOUT_TICKS + 1);
  localparam int c_ATT_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_BUSY   = 3'd2,
    S_CHECK  = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  state_t               r_state;
  logic                 r_lastGrant;
  logic [c_ATT_W-1:0]   r_attempt;
  logic [c_TIMER_W-1:0] r_timer;
  logic                 r_fail;
  logic [1:0]           r_grant;
  logic                 r_busy;
  logic [1:0]           r_done;
  logic [1:0]           r_err;
  logic [7:0]           r_rdData;
  logic [7:0]           r_errCount;
  logic                 r_go;
  logic                 r_wr;
  logic [23:0]          r_wdata;

  logic                 w_winner;
  logic                 w_timerLast;
  logic [7:0]           w_sub;
  logic [7:0]           w_data;

  // On a tie the port that did not win last time takes the engine
  always_comb begin
    w_winner = 1'b0;
    case (bus.req_valid)
      2'b01:   w_winner = 1'b0;
      2'b10:   w_winner = 1'b1;
      2'b11:   w_winner = ~r_lastGrant;
      default: w_winner = 1'b0;
    endcase
  end

  assign w_sub       = w_winner ? bus.req_sub_addr[15:8] : bus.req_sub_addr[7:0];
  assign w_data      = w_winner ? bus.req_wdata[15:8]    : bus.req_wdata[7:0];
  assign w_timerLast = (r_timer == c_TIMER_W'(TIMEOUT_TICKS - 1));

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state     <= S_IDLE;
      r_lastGrant <= 1'b1;
      r_attempt   <= '0;
      r_timer     <= '0;
      r_fail      <= 1'b0;
      r_grant     <= 2'b00;
      r_busy      <= 1'b0;
      r_done      <= 2'b00;
      r_err       <= 2'b00;
      r_rdData    <= 8'h00;
      r_errCount  <= 8'h00;
      r_go        <= 1'b0;
      r_wr        <= 1'b0;
      r_wdata     <= 24'h000000;
    end else begin
      r_done <= 2'b00;
      r_err  <= 2'b00;
      if (i2c_tick) begin
        case (r_state)
          S_IDLE: begin
            if (|bus.req_valid) begin
              r_grant     <= w_winner ? 2'b10 : 2'b01;
              r_busy      <= 1'b1;
              r_lastGrant <= w_winner;
              r_attempt   <= '0;
              r_timer     <= '0;
              r_fail      <= 1'b0;
              r_wr        <= w_winner ? bus.req_wr[1] : bus.req_wr[0];
              r_wdata     <= {SLAVE_ADDR, w_sub, w_data};
              r_go        <= 1'b1;
              r_state     <= S_LAUNCH;
            end
          end
          S_LAUNCH: begin
            if (!bus.eng_end) begin
              r_state <= S_BUSY;
            end else if (w_timerLast) begin
              r_go    <= 1'b0;
              r_fail  <= 1'b1;
              r_state <= S_CHECK;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          S_BUSY: begin
            if (bus.eng_end) begin
              r_go    <= 1'b0;
              r_fail  <= bus.eng_ack;
              r_state <= S_CHECK;
            end else if (w_timerLast) begin
              r_go    <= 1'b0;
              r_fail  <= 1'b1;
              r_state <= S_CHECK;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          S_CHECK: begin
            if (!r_fail) begin
              if (!r_wr) r_rdData <= bus.eng_rdata;
              r_done  <= r_grant;
              r_grant <= 2'b00;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else if (r_attempt != c_ATT_W'(MAX_RETRY)) begin
              r_attempt <= r_attempt + 1'b1;
              r_timer   <= '0;
              r_state   <= S_GAP;
            end else begin
              r_err   <= r_grant;
              if (r_errCount != 8'hFF) r_errCount <= r_errCount + 8'd1;
              r_grant <= 2'b00;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
          S_GAP: begin
            r_go    <= 1'b1;
            r_fail  <= 1'b0;
            r_state <= S_LAUNCH;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.req_done  = r_done;
  assign bus.req_err   = r_err;
  assign bus.rd_data   = r_rdData;
  assign bus.grant     = r_grant;
  assign bus.busy      = r_busy;
  assign bus.err_count = r_errCount;
  assign bus.eng_go    = r_go;
  assign bus.eng_wr    = r_wr;
  assign bus.eng_wdata = r_wdata;

endmodule

`default_nettype wire
